// File: rtl/execute_cycle_pkg.sv
// Shared execute-stage types: ALU opcodes (also used by decode) and the E->M pipeline record.
package execute_cycle_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        result_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] write_data;
    logic [31:0] alu_result;
  } m_stage_t;

endpackage

// File: rtl/execute_cycle_if.sv
// E-stage inputs, forwarding inputs and M-stage outputs of the execute stage.
interface execute_cycle_if;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E;
  logic [4:0]  RD_E;
  logic [31:0] PCE, PCPlus4E, ResultW;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW, ForwardA_E, ForwardB_E,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M,
           WriteDataM, ALU_ResultM
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW, ForwardA_E, ForwardB_E,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M,
           WriteDataM, ALU_ResultM
  );
endinterface

// File: rtl/execute_cycle_alu.sv
// Execute-stage ALU: add/sub/and/or/signed slt, everything else yields 0.
module alu
  import execute_cycle_pkg::*;
(
  input  logic [2:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        Zero
);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {31'b0, $signed(A) < $signed(B)};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution and the E->M pipeline register.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input logic             clk,
  input logic             rst,
  execute_cycle_if.slave  bus
);

  logic [31:0] src_a, fwd_b, src_b, alu_res;
  logic        zero;
  m_stage_t    m_q;

  // Forward from the registered M value only, so the A/B path has no loop back through the ALU.
  always_comb begin
    src_a = bus.RD1_E;
    case (bus.ForwardA_E)
      FWD_WB:  src_a = bus.ResultW;
      FWD_MEM: src_a = m_q.alu_result;
      default: src_a = bus.RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = bus.RD2_E;
    case (bus.ForwardB_E)
      FWD_WB:  fwd_b = bus.ResultW;
      FWD_MEM: fwd_b = m_q.alu_result;
      default: fwd_b = bus.RD2_E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;

  alu u_alu (
    .ALUControl (bus.ALUControlE),
    .A          (src_a),
    .B          (src_b),
    .Result     (alu_res),
    .Zero       (zero)
  );

  assign bus.PCSrcE    = zero & bus.BranchE;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q <= '0;
    end else begin
      m_q <= '{reg_write:  bus.RegWriteE,
               mem_write:  bus.MemWriteE,
               result_src: bus.ResultSrcE,
               rd:         bus.RD_E,
               pc_plus4:   bus.PCPlus4E,
               write_data: fwd_b,
               alu_result: alu_res};
    end
  end

  assign bus.RegWriteM   = m_q.reg_write;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.ResultSrcM  = m_q.result_src;
  assign bus.RD_M        = m_q.rd;
  assign bus.PCPlus4M    = m_q.pc_plus4;
  assign bus.WriteDataM  = m_q.write_data;
  assign bus.ALU_ResultM = m_q.alu_result;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: expected M records queued at drive time, popped after the edge.
module tb_execute_cycle;
  import execute_cycle_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_cycle_if bus ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  m_stage_t    exp_q[$];
  logic [31:0] mdl_alu_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, b);
    logic [31:0] r;
    unique case (op)
      3'd0: r = a + b;
      3'd1: r = a + (~b + 32'd1);
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf, wb, mem);
    return (sel == 2'b01) ? wb : (sel == 2'b10) ? mem : rf;
  endfunction

  // Apply E inputs, check the combinational branch outputs, queue the expected M record.
  task automatic apply(input logic rw, mw, rs, br, asrc, input logic [2:0] op,
                       input logic [31:0] rd1, rd2, imm, input logic [4:0] rd,
                       input logic [31:0] pc, resw, input logic [1:0] fa, fb);
    logic [31:0] a, b, res;
    m_stage_t e;
    bus.RegWriteE = rw; bus.MemWriteE = mw; bus.ResultSrcE = rs; bus.BranchE = br;
    bus.ALUSrcE = asrc; bus.ALUControlE = op; bus.RD1_E = rd1; bus.RD2_E = rd2;
    bus.Imm_Ext_E = imm; bus.RD_E = rd; bus.PCE = pc; bus.PCPlus4E = pc + 32'd4;
    bus.ResultW = resw; bus.ForwardA_E = fa; bus.ForwardB_E = fb;
    a   = ref_fwd(fa, rd1, resw, mdl_alu_m);
    b   = ref_fwd(fb, rd2, resw, mdl_alu_m);
    res = ref_alu(op, a, asrc ? imm : b);
    #1;
    chk("pcsrc", {31'b0, bus.PCSrcE}, {31'b0, br && (res == 32'd0)});
    chk("pctarget", bus.PCTargetE, pc + imm);
    e = '{reg_write: rw, mem_write: mw, result_src: rs, rd: rd, pc_plus4: pc + 32'd4,
          write_data: b, alu_result: res};
    exp_q.push_back(e);
  endtask

  task automatic step();
    m_stage_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("regwrite", {31'b0, bus.RegWriteM}, {31'b0, e.reg_write});
    chk("memwrite", {31'b0, bus.MemWriteM}, {31'b0, e.mem_write});
    chk("resultsrc", {31'b0, bus.ResultSrcM}, {31'b0, e.result_src});
    chk("rd_m", {27'b0, bus.RD_M}, {27'b0, e.rd});
    chk("pcplus4", bus.PCPlus4M, e.pc_plus4);
    chk("writedata", bus.WriteDataM, e.write_data);
    chk("aluresult", bus.ALU_ResultM, e.alu_result);
    mdl_alu_m = e.alu_result;
  endtask

  task automatic chk_m_zero(input string tag);
    chk({tag, "_regwrite"}, {31'b0, bus.RegWriteM}, 32'd0);
    chk({tag, "_memwrite"}, {31'b0, bus.MemWriteM}, 32'd0);
    chk({tag, "_resultsrc"}, {31'b0, bus.ResultSrcM}, 32'd0);
    chk({tag, "_rd"}, {27'b0, bus.RD_M}, 32'd0);
    chk({tag, "_pcplus4"}, bus.PCPlus4M, 32'd0);
    chk({tag, "_writedata"}, bus.WriteDataM, 32'd0);
    chk({tag, "_aluresult"}, bus.ALU_ResultM, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(1, 1, 1, 0, 0, 3'd0, 32'h11, 32'h22, 32'h4, 5'd9, 32'h40, 32'h0, 2'b00, 2'b00);
    exp_q.delete();
    #3;
    chk_m_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // add 5 + 7
    apply(1, 0, 0, 0, 0, ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 32'h0, 32'h0, 2'b00, 2'b00);
    step();
    chk("add_res", bus.ALU_ResultM, 32'd12);
    chk("add_wd", bus.WriteDataM, 32'd7);

    // beq taken
    apply(0, 0, 0, 1, 0, ALU_SUB, 32'h10, 32'h10, 32'h20, 5'd0, 32'h100, 32'h0, 2'b00, 2'b00);
    chk("beq_pcsrc", {31'b0, bus.PCSrcE}, 32'd1);
    chk("beq_target", bus.PCTargetE, 32'h120);
    step();

    // back-to-back forwarding from M and W
    apply(1, 0, 0, 0, 0, ALU_ADD, 32'd4, 32'd5, 32'd0, 5'd1, 32'h200, 32'h0, 2'b00, 2'b00);
    step();
    chk("fwd_c1", bus.ALU_ResultM, 32'd9);
    apply(1, 1, 0, 0, 1, ALU_ADD, 32'd0, 32'h99, 32'd3, 5'd2, 32'h204, 32'h55, 2'b10, 2'b01);
    step();
    chk("fwd_c2", bus.ALU_ResultM, 32'd12);
    chk("fwd_wd", bus.WriteDataM, 32'h55);

    // signed slt and wrap-around add
    apply(1, 0, 0, 0, 0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd4, 32'h300, 32'h0, 2'b00, 2'b00);
    step();
    chk("slt", bus.ALU_ResultM, 32'd1);
    apply(1, 0, 0, 0, 0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, 32'h304, 32'h0, 2'b00, 2'b00);
    step();
    chk("wrap", bus.ALU_ResultM, 32'd0);

    // store with immediate operand: store data stays forwarded B
    apply(0, 1, 0, 0, 1, ALU_ADD, 32'h1000, 32'hCAFE, 32'h8, 5'd0, 32'h308, 32'h0, 2'b00, 2'b11);
    step();
    chk("st_wd", bus.WriteDataM, 32'hCAFE);

    // async reset mid-cycle discards the in-flight record
    apply(1, 1, 1, 0, 0, ALU_OR, 32'hF0, 32'h0F, 32'h40, 5'd7, 32'h400, 32'h0, 2'b00, 2'b00);
    step();
    apply(1, 1, 1, 1, 0, ALU_AND, 32'hAB, 32'hFF, 32'h40, 5'd8, 32'h404, 32'h0, 2'b00, 2'b00);
    exp_q.delete();
    #2 rst = 1'b0;
    #1;
    chk_m_zero("arst");
    chk("arst_target", bus.PCTargetE, 32'h444);
    mdl_alu_m = '0;
    #1 rst = 1'b1;
    apply(1, 1, 1, 1, 0, ALU_AND, 32'hAB, 32'hFF, 32'h40, 5'd8, 32'h404, 32'h0, 2'b10, 2'b00);
    step();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] r1, r2;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      apply($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
            r1, r2, $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
